inst_mem_sync: RTL and testbench

//  Parametrised, synchronous instruction memory for the MIPS fetch stage. Replaces the

---
 rtl/inst_mem_sync.sv | 114 +++++++++++
 tb/tb_inst_mem_sync.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory for the fetch stage: registered read, loader write
// port, and a post-reset sweep that clears every word to NOP before accepting traffic.
module inst_mem_sync #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              Stall,
  output logic              Ready,
  output logic [DATA_W-1:0] Inst,
  output logic              InstValid,
  output logic              Fault,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [DATA_W-1:0] LoadData,
  output logic              LoadErr,
  output logic              dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Fetch handshake: a request is taken on an edge where FetchReq & Ready & ~Stall;
  // its result (Inst/Fault) appears with InstValid=1 after that edge and, while Stall
  // is high, every fetch output holds unchanged.
  logic [IDX_W-1:0] fetch_idx, load_idx;
  logic             fetch_ok, load_ok, accept;

  // Range check on the high bits keeps out-of-range PCs from aliasing onto low words.
  assign fetch_idx = Addr[IDX_W+1:2];
  assign fetch_ok  = (Addr[1:0] == 2'b00) && (Addr[ADDR_W-1:IDX_W+2] == '0);
  assign load_idx  = LoadAddr[IDX_W+1:2];
  assign load_ok   = LoadEn && Ready && (LoadAddr[1:0] == 2'b00)
                     && (LoadAddr[ADDR_W-1:IDX_W+2] == '0);
  assign accept    = FetchReq && Ready && !Stall;

  assign Ready     = (state_q == ST_READY);
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_READY;
      end
      ST_READY: begin
        if (load_ok) begin
          mem_we    = 1'b1;
          mem_waddr = load_idx;
          mem_wdata = LoadData;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      Inst      <= '0;
      InstValid <= 1'b0;
      Fault     <= 1'b0;
      LoadErr   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      LoadErr <= LoadEn && !load_ok;
      if (!Stall) begin
        if (accept) begin
          InstValid <= 1'b1;
          if (fetch_ok) begin
            Fault <= 1'b0;
            Inst  <= mem[fetch_idx];
          end else begin
            Fault <= 1'b1;
            Inst  <= '0;
          end
        end else begin
          InstValid <= 1'b0;
          Fault     <= 1'b0;
        end
      end
    end
  end

  // Read above samples the old word, so a same-edge load is seen by the next fetch.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_inst_mem_sync.sv
// Directed bench for inst_mem_sync: init sweep timing, load/fetch, faults, stall
// hold, read-before-write and reset in both FSM states.
module tb_inst_mem_sync;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        FetchReq;
  logic [31:0] Addr;
  logic        Stall;
  logic        Ready;
  logic [31:0] Inst;
  logic        InstValid;
  logic        Fault;
  logic        LoadEn;
  logic [31:0] LoadAddr;
  logic [31:0] LoadData;
  logic        LoadErr;
  logic        dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  inst_mem_sync #(.DATA_W(32), .DEPTH(32), .ADDR_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .FetchReq(FetchReq), .Addr(Addr), .Stall(Stall),
    .Ready(Ready), .Inst(Inst), .InstValid(InstValid), .Fault(Fault),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData), .LoadErr(LoadErr),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    step();
    LoadEn = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    FetchReq = 1'b1; Addr = a;
    step();
    FetchReq = 1'b0;
  endtask

  // Fetch and score the returned word against the expected queue.
  task automatic fetch_chk(input string tag, input logic [31:0] a, input logic [31:0] exp,
                           input logic exp_fault);
    exp_q.push_back(exp);
    do_fetch(a);
    check({tag, "_inst"}, Inst, exp_q.pop_front());
    check({tag, "_valid"}, {31'b0, InstValid}, 32'd1);
    check({tag, "_fault"}, {31'b0, Fault}, {31'b0, exp_fault});
  endtask

  task automatic wait_ready(input string tag, input int start);
    int cnt;
    cnt = start;
    while (!Ready && cnt < 100) begin
      step();
      cnt++;
    end
    check(tag, cnt, 32'd32);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, {31'b0, Ready}, 32'd0);
    check({tag, "_inst"}, Inst, 32'd0);
    check({tag, "_valid"}, {31'b0, InstValid}, 32'd0);
    check({tag, "_fault"}, {31'b0, Fault}, 32'd0);
    check({tag, "_lerr"}, {31'b0, LoadErr}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; FetchReq = 1'b0; Addr = '0; Stall = 1'b0;
    LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
    step();
    step();
    check_zero("t1_rst");
    Reset = 1'b0;

    // First edge after release: load rejected and fetch ignored during INIT
    LoadEn = 1'b1; LoadAddr = 32'h0; LoadData = 32'hDEAD_BEEF;
    FetchReq = 1'b1; Addr = 32'h0;
    step();
    LoadEn = 1'b0; FetchReq = 1'b0;
    check("t1_init_lerr", {31'b0, LoadErr}, 32'd1);
    check("t1_init_valid", {31'b0, InstValid}, 32'd0);
    wait_ready("t1_ready_edges", 1);
    fetch_chk("t1_f0", 32'h0, 32'h0, 1'b0);

    // T2 load then fetch
    do_load(32'h0C, 32'h0043_0820);
    check("t2_lerr", {31'b0, LoadErr}, 32'd0);
    fetch_chk("t2_f0c", 32'h0C, 32'h0043_0820, 1'b0);
    step();
    check("t2_idle_valid", {31'b0, InstValid}, 32'd0);
    check("t2_idle_hold", Inst, 32'h0043_0820);

    // T3 faults and rejected loads
    fetch_chk("t3_mis", 32'h0E, 32'h0, 1'b1);
    fetch_chk("t3_oor", 32'h80, 32'h0, 1'b1);
    fetch_chk("t3_alias", 32'h8C, 32'h0, 1'b1);
    do_load(32'h84, 32'hFFFF_FFFF);
    check("t3_lerr_oor", {31'b0, LoadErr}, 32'd1);
    step();
    check("t3_lerr_pulse", {31'b0, LoadErr}, 32'd0);
    do_load(32'h0D, 32'hFFFF_FFFF);
    check("t3_lerr_mis", {31'b0, LoadErr}, 32'd1);
    fetch_chk("t3_f0c", 32'h0C, 32'h0043_0820, 1'b0);
    fetch_chk("t3_f04", 32'h04, 32'h0, 1'b0);

    // T4 stall hold
    do_load(32'h10, 32'hA5A5_0004);
    fetch_chk("t4_f0c", 32'h0C, 32'h0043_0820, 1'b0);
    Stall = 1'b1; FetchReq = 1'b1; Addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_inst", Inst, 32'h0043_0820);
      check("t4_hold_valid", {31'b0, InstValid}, 32'd1);
    end
    Stall = 1'b0;
    step();
    FetchReq = 1'b0;
    check("t4_rel_inst", Inst, 32'hA5A5_0004);
    check("t4_rel_valid", {31'b0, InstValid}, 32'd1);

    // T5 same-cycle load and fetch: read before write
    LoadEn = 1'b1; LoadAddr = 32'h14; LoadData = 32'h1234_5678;
    FetchReq = 1'b1; Addr = 32'h14;
    step();
    LoadEn = 1'b0; FetchReq = 1'b0;
    check("t5_old", Inst, 32'h0);
    check("t5_lerr", {31'b0, LoadErr}, 32'd0);
    fetch_chk("t5_new", 32'h14, 32'h1234_5678, 1'b0);

    // T6 reset in READY, then again mid-sweep
    Reset = 1'b1;
    #1;
    check_zero("t6_rdy_rst");
    step();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("t6_mid_ready", {31'b0, Ready}, 32'd0);
    Reset = 1'b1;
    #1;
    check_zero("t6_mid_rst");
    step();
    Reset = 1'b0;
    wait_ready("t6_ready_edges", 0);
    fetch_chk("t6_cleared", 32'h0C, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
